seq_booth_mult: RTL and testbench

Sequential signed multiplier for the complex-multiplier datapath. It consumes two's-complement 16-bit operands produced by the serial two's-complement stage, for example the negated imaginary term used in ac − bd. It forms the full-precision signed product with a radix-2 Booth shift/add FSM, one Booth step per clock. Operands enter through a start/busy/done handshake, and the result is held until the next accepted start.

---
 rtl/mult_pkg.sv | 38 +++
 rtl/seq_booth_mult_booth_step.sv | 47 ++++
 rtl/seq_booth_mult.sv | 141 ++++++++++++++
 tb/tb_seq_booth_mult.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential Booth multiplier slice.
//   - DATA_W / PROD_W : default operand and product widths
//   - COUNT_W         : Booth step counter width for DATA_W operands
//   - state_t         : 2-bit FSM encoding (IDLE=00, RUN=01, DONE=10, 11 illegal)
//   - booth_op_t      : action chosen by the {Q[0], Q-1} bit pair
//   - booth_decode()  : maps the bit pair to its Booth action
package mult_pkg;

    localparam int DATA_W  = 16;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int COUNT_W = $clog2(DATA_W);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } booth_op_t;

    // Radix-2 Booth recoding: 10 starts a run of ones (subtract),
    // 01 ends one (add), 00/11 are inside a run (no arithmetic).
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// booth_step
// One combinational radix-2 Booth iteration: conditional add/subtract of
// the multiplicand into the accumulator, then an arithmetic right shift of
// the whole {ACC, Q, Q-1} triple by one bit.
// Ports:
//   acc_in  / acc_out : WIDTH+1 bit accumulator (extra bit holds -2^(WIDTH-1) magnitudes)
//   q_in    / q_out   : WIDTH bit multiplier / low product bits
//   qm1_in  / qm1_out : the Q-1 guard bit
//   m_in              : sign-extended multiplicand, WIDTH+1 bits
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             qm1_in,
    input  logic [WIDTH:0]   m_in,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qm1_out
);

    booth_op_t      op_s;
    logic [WIDTH:0] sum_s;

    assign op_s = booth_decode(q_in[0], qm1_in);

    // Accumulator update selected by the Booth bit pair.
    always_comb begin
        sum_s = acc_in;
        case (op_s)
            OP_ADD:  sum_s = acc_in + m_in;
            OP_SUB:  sum_s = acc_in - m_in;
            OP_HOLD: sum_s = acc_in;
            default: sum_s = acc_in;
        endcase
    end

    // Arithmetic shift right of {ACC, Q, Q-1}; ACC sign bit is replicated.
    always_comb begin
        acc_out = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_out   = {sum_s[0], q_in[WIDTH-1:1]};
        qm1_out = q_in[0];
    end

endmodule

// File: rtl/seq_booth_mult.sv
// seq_booth_mult
// Sequential signed multiplier: full-precision 2*WIDTH-bit product of two
// WIDTH-bit two's-complement operands, one radix-2 Booth step per clock.
// Ports:
//   clk     : system clock, all state on posedge
//   reset   : synchronous active-high reset, highest priority
//   start   : request; operands a/b captured on the accepting edge
//   a, b    : signed multiplicand / multiplier
//   product : registered signed result, held until the next completion
//   busy    : high while the Booth steps are running (WIDTH cycles)
//   done    : one-cycle pulse when product becomes valid
// All outputs are driven straight from flops.
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);

    state_t               state_r;
    logic [WIDTH:0]       acc_r;
    logic [WIDTH-1:0]     q_r;
    logic                 qm1_r;
    logic [WIDTH:0]       m_r;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH:0]       acc_nxt_s;
    logic [WIDTH-1:0]     q_nxt_s;
    logic                 qm1_nxt_s;
    logic                 accept_s;
    logic                 last_step_s;

    booth_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .acc_in  (acc_r),
        .q_in    (q_r),
        .qm1_in  (qm1_r),
        .m_in    (m_r),
        .acc_out (acc_nxt_s),
        .q_out   (q_nxt_s),
        .qm1_out (qm1_nxt_s)
    );

    // Start acceptance. The DONE cycle also accepts, so a held start gets
    // one product every WIDTH+1 cycles; RUN never accepts (no queuing).
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Final Booth step of the current operation.
    always_comb begin
        last_step_s = 1'b0;
        if (state_r == ST_RUN) begin
            last_step_s = (count_r == LAST_COUNT);
        end else begin
            last_step_s = 1'b0;
        end
    end

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            acc_r     <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            qm1_r     <= 1'b0;
            m_r       <= {(WIDTH+1){1'b0}};
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (accept_s) begin
            state_r <= ST_RUN;
            m_r     <= {a[WIDTH-1], a};
            q_r     <= b;
            qm1_r   <= 1'b0;
            acc_r   <= {(WIDTH+1){1'b0}};
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                ST_RUN: begin
                    acc_r   <= acc_nxt_s;
                    q_r     <= q_nxt_s;
                    qm1_r   <= qm1_nxt_s;
                    count_r <= count_r + COUNT_ONE;
                    if (last_step_s) begin
                        // Low 2*WIDTH bits of the shifted {ACC, Q}; the
                        // extra ACC bit is only a guard and is dropped.
                        product_r <= {acc_nxt_s[WIDTH-1:0], q_nxt_s};
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    // Illegal code 11: recover to IDLE.
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign product = product_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_seq_booth_mult.sv
module tb_seq_booth_mult;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    seq_booth_mult #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the operands.
    function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] r;
        r = $signed(x) * $signed(y);
        return r;
    endfunction

    // One start pulse, then watch busy/done until done or timeout.
    // done_cyc = number of falling edges after the accepting edge at which done is seen.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          output logic [31:0] p, output int busy_cnt, output int done_cyc,
                          output int overlap);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h5A5A; b = 16'hA5A5;
        busy_cnt = 0; done_cyc = -1; overlap = 0; p = 32'h0;
        if (busy) busy_cnt++;
        for (int i = 2; i <= 40 && done_cyc < 0; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (done) begin
                done_cyc = i;
                p = product;
            end
        end
    endtask

    initial begin
        logic [31:0] p;
        int          bc, dc, ov, pulses;
        int          dcyc[$];
        logic [31:0] dprod[$];
        logic [15:0] ra, rb;

        tests_run = 0; tests_failed = 0;
        reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;

        vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{16'hFFF9, 16'd6,    32'hFFFFFFD6};
        vecs[2] = '{16'd6,    16'hFFF9, 32'hFFFFFFD6};
        vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[4] = '{16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[5] = '{16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[8] = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[9] = '{16'h8000, 16'hFFFF, 32'h00008000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_product", product, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, p, bc, dc, ov);
            check($sformatf("vec%0d_product", i), p, vecs[i].exp);
            check($sformatf("vec%0d_done_cycle", i), dc, 32'd17);
            check($sformatf("vec%0d_busy_cycles", i), bc, 32'd16);
            check($sformatf("vec%0d_busy_done_overlap", i), ov, 32'd0);
        end

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, p, bc, dc, ov);
            check($sformatf("rand%0d_%04h_x_%04h", i, ra, rb), p, ref_mult(ra, rb));
        end

        // Start raised with new operands during RUN must be ignored.
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        pulses = 0; p = 32'h0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (done) begin pulses++; p = product; end
            if (k >= 1 && k <= 14) begin
                start = 1'b1; a = 16'd100; b = 16'd100;
            end else begin
                start = 1'b0;
            end
        end
        check("ignored_start_product", p, 32'h0000000F);
        check("ignored_start_pulses", pulses, 32'd1);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 16'd1000; b = 16'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 7) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_product", product, 32'h0);
        check("midrun_reset_busy", {31'h0, busy}, 32'h0);
        check("midrun_reset_done", {31'h0, done}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrun_reset_no_activity", pulses, 32'd0);
        run_op(16'd1000, 16'd1000, p, bc, dc, ov);
        check("after_reset_product", p, 32'h000F4240);
        check("after_reset_done_cycle", dc, 32'd17);

        // Reset and start on the same edge: start is not accepted.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; a = 16'd9; b = 16'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_start_busy", {31'h0, busy}, 32'h0);
        check("reset_start_product", product, 32'h0);

        // Back-to-back with start held high.
        @(negedge clk);
        a = 16'd2; b = 16'hFFFD; start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc.push_back(k);
                dprod.push_back(product);
            end
        end
        start = 1'b0;
        check("b2b_pulse_count", dcyc.size(), 32'd3);
        if (dcyc.size() == 3) begin
            check("b2b_first_done", dcyc[0], 32'd16);
            check("b2b_period1", dcyc[1] - dcyc[0], 32'd17);
            check("b2b_period2", dcyc[2] - dcyc[1], 32'd17);
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b_product%0d", i), dprod[i], 32'hFFFFFFFA);
        end
        repeat (20) @(negedge clk);
        check("b2b_idle_after", {30'h0, busy, done}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
